// File: rtl/div_seq.sv
// Sequential signed divider: one restoring quotient bit per cycle, with a one-cycle
// short-circuit for divisors 0 and -1 and a one-cycle ready pulse on completion.
module div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    count, count_nxt;
   logic [WIDTH-1:0] a_q, a_nxt;
   logic [WIDTH-1:0] b_q, b_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] dvs, dvs_nxt;
   logic             neg, neg_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic             exc_nxt;
   logic             rdy_nxt;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic [WIDTH-1:0] quo_fin;

   // State and datapath registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         count          <= '0;
         a_q            <= '0;
         b_q            <= '0;
         rem            <= '0;
         quo            <= '0;
         dvs            <= '0;
         neg            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         state          <= state_nxt;
         count          <= count_nxt;
         a_q            <= a_nxt;
         b_q            <= b_nxt;
         rem            <= rem_nxt;
         quo            <= quo_nxt;
         dvs            <= dvs_nxt;
         neg            <= neg_nxt;
         data_result    <= res_nxt;
         data_exception <= exc_nxt;
         data_resultRDY <= rdy_nxt;
      end
   end

   // Next-state, iteration step and result selection
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      a_nxt     = a_q;
      b_nxt     = b_q;
      rem_nxt   = rem;
      quo_nxt   = quo;
      dvs_nxt   = dvs;
      neg_nxt   = neg;
      res_nxt   = data_result;
      exc_nxt   = data_exception;

      // rem < dvs <= 2^31, so the 33-bit difference never wraps its sign
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      q_bit   = ~diff[WIDTH];
      quo_fin = {quo[WIDTH-2:0], q_bit};

      if (ctrl_DIV) begin
         state_nxt = ITER;
         count_nxt = '0;
         a_nxt     = data_operandA;
         b_nxt     = data_operandB;
         rem_nxt   = '0;
         quo_nxt   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
         dvs_nxt   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
         neg_nxt   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      end else begin
         case (state)
            ITER: begin
               if (b_q == '0) begin
                  state_nxt = DONE;
                  res_nxt   = '0;
                  exc_nxt   = 1'b1;
               end else if (b_q == ALL_ONES) begin
                  state_nxt = DONE;
                  res_nxt   = -a_q;
                  exc_nxt   = (a_q == INT_MIN);
               end else begin
                  rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                  quo_nxt = quo_fin;
                  if (count == CW'(WIDTH-1)) begin
                     state_nxt = DONE;
                     res_nxt   = neg ? -quo_fin : quo_fin;
                     exc_nxt   = 1'b0;
                  end else begin
                     count_nxt = count + CW'(1);
                  end
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end

      rdy_nxt = (state_nxt == DONE);
   end

endmodule
